// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: host command sequencer that fills CPU imem/dmem, resets and runs the CPU.
// Optional run watchdog is compiled in with `define CPU_WATCHDOG_EN.
module cpu_prog_loader #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [1:0]        resp_status,
   output logic [15:0]       resp_data,
   output logic              cpu_rst_n,
   input  logic              cpu_done,
   input  logic [DATA_W-1:0] cpu_out_r,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              ex_iwe,
   output logic [ADDR_W-1:0] ex_iaddr,
   output logic [DATA_W-1:0] ex_idata,
   output logic              ex_dwe,
   output logic [ADDR_W-1:0] ex_daddr,
   output logic [DATA_W-1:0] ex_ddata
);
   // state | meaning
   // IDLE  | waiting for command word0
   // HDR1  | waiting for len_m1 of a LOAD
   // LOAD  | accepting data words, one memory write per word
   // RUN   | CPU released from reset, counting cycles until done
   // RESP  | holding the response until resp_ready
   typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LOAD, S_RUN, S_RESP} state_t;

   localparam logic [1:0] CMD_LOAD_I = 2'b00;
   localparam logic [1:0] CMD_LOAD_D = 2'b01;
   localparam logic [1:0] CMD_RUN    = 2'b10;
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_HALTED  = 2'b01;
`ifdef CPU_WATCHDOG_EN
   localparam logic [1:0]  ST_TIMEOUT = 2'b10;
   localparam logic [15:0] WDOG_LIM   = 16'(WDOG_CYCLES);
`endif

   if (DATA_W < 16 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_param
      $error("cpu_prog_loader: unsupported parameter set");
   end

   state_t              state_q, state_d;
   logic [15:0]         word0_q, word0_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                halt_q, halt_d;
   logic [15:0]         run_cnt_q, run_cnt_d;
   logic [1:0]          status_q, status_d;
   logic [15:0]         rdata_q, rdata_d;
   logic                cpu_rst_n_q, cpu_rst_n_d;
   logic                iwe_q, iwe_d, dwe_q, dwe_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                alive_q;
   logic                accept;

   // alive_q keeps in_ready low while rst_n is asserted even though the FSM sits in IDLE
   assign in_ready = alive_q & ((state_q == S_IDLE) | (state_q == S_HDR1) | (state_q == S_LOAD));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         word0_q     <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         halt_q      <= 1'b0;
         run_cnt_q   <= '0;
         status_q    <= '0;
         rdata_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         iwe_q       <= 1'b0;
         dwe_q       <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         alive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         word0_q     <= word0_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         halt_q      <= halt_d;
         run_cnt_q   <= run_cnt_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         iwe_q       <= iwe_d;
         dwe_q       <= dwe_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         alive_q     <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      word0_d     = word0_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      halt_d      = halt_q;
      run_cnt_d   = run_cnt_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      iwe_d       = 1'b0;
      dwe_d       = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               word0_d = in_data[15:0];
               case (in_data[15:14])
                  CMD_LOAD_I, CMD_LOAD_D: begin
                     addr_d      = in_data[ADDR_W-1:0];
                     // dmem writes are lost while the halted CPU's clock is gated
                     halt_d      = (in_data[15:14] == CMD_LOAD_D) & cpu_done;
                     cpu_rst_n_d = 1'b0;
                     state_d     = S_HDR1;
                  end
                  CMD_RUN: begin
                     run_cnt_d   = '0;
                     cpu_rst_n_d = 1'b1;
                     state_d     = S_RUN;
                  end
                  default: begin
                     cpu_rst_n_d = 1'b0;
                     status_d    = ST_OK;
                     rdata_d     = in_data[15:0];
                     state_d     = S_RESP;
                  end
               endcase
            end
         end
         S_HDR1: begin
            if (accept) begin
               cnt_d   = in_data[7:0];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (!halt_q) begin
                  iwe_d = (word0_q[15:14] == CMD_LOAD_I);
                  dwe_d = (word0_q[15:14] == CMD_LOAD_D);
               end
               waddr_d = addr_q;
               wdata_d = in_data;
               addr_d  = addr_q + 1'b1;
               if (cnt_q == 8'd0) begin
                  status_d = halt_q ? ST_HALTED : ST_OK;
                  rdata_d  = word0_q;
                  state_d  = S_RESP;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_RUN: begin
            if (cpu_out_r != '0) begin
               out_valid_d = 1'b1;
               out_data_d  = cpu_out_r;
            end
            if (cpu_done) begin
               status_d = ST_OK;
               rdata_d  = run_cnt_q;
               state_d  = S_RESP;
            end
`ifdef CPU_WATCHDOG_EN
            else if (run_cnt_q == WDOG_LIM) begin
               status_d    = ST_TIMEOUT;
               rdata_d     = WDOG_LIM;
               cpu_rst_n_d = 1'b0;
               state_d     = S_RESP;
            end
`endif
            else if (run_cnt_q != 16'hFFFF) begin
               run_cnt_d = run_cnt_q + 16'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_valid  = (state_q == S_RESP);
   assign resp_status = status_q;
   assign resp_data   = rdata_q;
   assign cpu_rst_n   = cpu_rst_n_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign ex_iwe      = iwe_q;
   assign ex_dwe      = dwe_q;
   assign ex_iaddr    = waddr_q;
   assign ex_daddr    = waddr_q;
   assign ex_idata    = wdata_q;
   assign ex_ddata    = wdata_q;
endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Host-side sequencer for the single-cycle 16-bit CPU.
- Receives a word stream of commands and uses it to fill instruction and data memory through the CPU's ex_iwe/ex_iaddr/ex_idata and ex_dwe/ex_daddr/ex_ddata ports.
- Controls the CPU reset, launches execution and counts cycles until the CPU halt flag rises.
- Returns one status/result word per command on a response stream and forwards nonzero Out_R values.

Parameters:
ADDR_W, 8, memory address width; matches the CPU's ex_iaddr/ex_daddr.
DATA_W, 16, memory word width.
WDOG_CYCLES, 4096, run-cycle limit; used only with CPU_WATCHDOG_EN.

Ports:
clk_i  in  1  system clock, shared with the CPU
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  command-stream word valid
in_ready  out  1  loader accepts the word this cycle
in_data  in  DATA_W  command-stream word
resp_valid  out  1  response valid
resp_ready  in  1  host accepts the response
resp_status  out  2  00 OK, 01 HALTED, 10 TIMEOUT
resp_data  out  16  echoed command or run cycle count
cpu_rst_n  out  1  CPU reset, active low, registered
cpu_done  in  1  CPU flag_done
cpu_out_r  in  DATA_W  CPU Out_R
out_valid  out  1  one-cycle strobe: out_data updated
out_data  out  DATA_W  last nonzero Out_R
ex_iwe / ex_dwe  out  1  imem / dmem external write enables
ex_iaddr / ex_daddr  out  ADDR_W  write addresses
ex_idata / ex_ddata  out  DATA_W  write data

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, including cpu_rst_n=0 (CPU held in reset). State IDLE.
- Command format:
  - Word0: [15:14] cmd, [7:0] start address. cmd 00=LOAD_I, 01=LOAD_D, 10=RUN, 11=RESET.
  - Word1 is sent only for LOAD commands: [7:0] len_m1. It is followed by len_m1+1 data words.
- States: IDLE -> HDR1 (LOAD) -> LOAD -> RESP; IDLE -> RUN -> RESP; IDLE -> RESP (RESET). RESP -> IDLE on resp_valid & resp_ready.
- in_ready:
  - =1 in IDLE, HDR1 and LOAD.
  - =0 in RUN and RESP.
  - Words are transferred only on in_valid & in_ready.
- LOAD_I / LOAD_D header:
  - Accepting the header drives cpu_rst_n=0 from the next cycle.
  - Address counter is loaded with start address; word counter with len_m1.
- LOAD data words:
  - Each accepted word produces exactly one registered write cycle on the next cycle: ex_*we=1 with the current address and the word.
  - Address then increments modulo 2^ADDR_W; 255 wraps to 0.
  - After the word with counter==0: go to RESP, status OK, resp_data = word0.
- LOAD_D guard:
  - The CPU clock is gated while flag_done=1, so dmem writes would be lost.
  - If cpu_done=1 when the LOAD_D header is accepted: still consume len_m1+1 words, issue no ex_dwe, respond HALTED.
- RUN:
  - cpu_rst_n=1 from the first RUN cycle.
  - A 16-bit counter, cleared on entry, increments each cycle while cpu_done=0. It saturates at 16'hFFFF.
  - On cpu_done=1: go to RESP, status OK, resp_data = count.
  - cpu_rst_n stays 1 after the run, so CPU state remains observable.
- RESET: drive cpu_rst_n=0, respond OK with resp_data = word0.
- RESP: resp_valid holds with stable status and data until resp_ready. Deassert on the handshake cycle; next state IDLE.
- Out_R monitor:
  - In RUN, any cycle with cpu_out_r != 0 produces, next cycle: out_data = cpu_out_r, out_valid=1 for one cycle.
  - No backpressure. Outside RUN, out_valid=0.
- ex_iwe and ex_dwe are never high in the same cycle.
- Reset mid-operation: everything returns to reset values immediately. Any partial load is abandoned.

Optional Feature:
- CPU_WATCHDOG_EN defined:
  - If the RUN counter reaches WDOG_CYCLES with cpu_done still 0: go to RESP, status TIMEOUT, resp_data=WDOG_CYCLES.
  - cpu_rst_n is driven 0 from the next cycle.
- CPU_WATCHDOG_EN undefined: RUN waits for cpu_done indefinitely and the counter saturates. The TIMEOUT status is never produced.

Test Plan:
- LOAD_I word0=16'h0010, len_m1=2, data A1,A2,A3 -> ex_iwe pulses at iaddr 10,11,12 with A1..A3, each one cycle after acceptance; resp OK, data 16'h0010.
- LOAD_D start=8'hFE, len_m1=3 -> ex_daddr sequence FE,FF,00,01 (wrap); resp OK.
- RUN with model asserting cpu_done 25 cycles after entry -> cpu_rst_n=1 throughout the run; resp OK, data 16'd25; a cpu_out_r=16'h0042 pulse gives out_valid with out_data=16'h0042.
- LOAD_D issued while cpu_done=1 -> all words consumed, no ex_dwe; resp HALTED; then RESET -> cpu_rst_n=0, resp OK.
- Hold resp_ready=0 for 5 cycles -> resp_valid/status/data stable, in_ready=0; rst_n low mid-LOAD -> all outputs 0 asynchronously.
- With CPU_WATCHDOG_EN, WDOG_CYCLES=100, cpu_done never set -> resp TIMEOUT, data 16'd100, cpu_rst_n=0.
